// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and timer helper for the hazard scoreboard.
// Build option: HAZARD_FORWARDING_EN adds a forwarding-ready timer per register.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDRESS_LEN     = 4;
    localparam int unsigned DEFAULT_MAX_LAT     = 3;
    localparam int unsigned DEFAULT_STALL_CNT_W = 16;

    // Widest timer the helper below supports; entries zero-extend into it.
    localparam int unsigned MAX_CNT_W = 8;

    // One edge of a countdown timer: decrement towards zero, or on load take the larger
    // of the new latency and the decremented value so a WAW never shortens the entry.
    function automatic logic [MAX_CNT_W-1:0] timer_next(
        input logic [MAX_CNT_W-1:0] cur,
        input logic                 load,
        input logic [MAX_CNT_W-1:0] val
    );
        logic [MAX_CNT_W-1:0] dec;
        dec = (cur == '0) ? '0 : cur - 1'b1;
        if (load && (val > dec)) begin
            return val;
        end
        return dec;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// Scoreboard entry for one architectural register: writeback countdown timer.
// Build option: HAZARD_FORWARDING_EN adds a second timer for forwarding readiness.
module hazard_scoreboard_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] lat_i,
`ifdef HAZARD_FORWARDING_EN
    input  logic [CNT_W-1:0] fwd_lat_i,
`endif
    output logic             busy_o,
    output logic [CNT_W-1:0] chk_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d  = CNT_W'(timer_next(MAX_CNT_W'(cnt_q), load_i, MAX_CNT_W'(lat_i)));
    assign busy_o = (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    assign fcnt_d = CNT_W'(timer_next(MAX_CNT_W'(fcnt_q), load_i, MAX_CNT_W'(fwd_lat_i)));
    assign chk_o  = fcnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    assign chk_o = cnt_q;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-tracking hazard scoreboard: per-register writeback timers, operand match, stall counter.
// Build option: HAZARD_FORWARDING_EN checks forwarding readiness instead of writeback.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = REG_ADDRESS_LEN,
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned MAX_LAT     = DEFAULT_MAX_LAT,
    parameter int unsigned CNT_W       = $clog2(MAX_LAT + 1),
    parameter int unsigned STALL_CNT_W = DEFAULT_STALL_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic                          issue_valid,
    input  logic                          issue_wb_en,
    input  logic [REG_ADDR_W-1:0]         issue_dest,
    input  logic [CNT_W-1:0]              issue_lat,
    input  logic [CNT_W-1:0]              issue_fwd_lat,
    input  logic                          flush,
    output logic                          hazard,
    output logic [(2**REG_ADDR_W)-1:0]    busy_mask,
    output logic [STALL_CNT_W-1:0]        stall_count
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

    logic [CNT_W-1:0]       lat_clamp;
    logic [CNT_W-1:0]       chk [NUM_REGS];
    logic [NUM_SRC-1:0]     conflict;
    logic                   accept;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    assign lat_clamp = (issue_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issue_lat;

`ifdef HAZARD_FORWARDING_EN
    logic [CNT_W-1:0] fwd_clamp;
    assign fwd_clamp = (issue_fwd_lat < lat_clamp) ? issue_fwd_lat : lat_clamp;
`else
    logic unused_fwd_lat;
    assign unused_fwd_lat = ^issue_fwd_lat;
`endif

    // Conflicts look only at stored timers, so a self-dependent issue sees the old entry.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            conflict[i] = src_valid[i] && (chk[src_addr[i*REG_ADDR_W +: REG_ADDR_W]] != '0);
        end
    end

    assign hazard = issue_valid && !flush && (|conflict);
    assign accept = issue_valid && !flush && !hazard && issue_wb_en && (issue_lat != '0);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        hazard_scoreboard_entry #(
            .CNT_W (CNT_W)
        ) u_scoreboard_entry (
            .clk_i     (clk),
            .rst_i     (rst),
            .load_i    (accept && (issue_dest == REG_ADDR_W'(r))),
            .lat_i     (lat_clamp),
`ifdef HAZARD_FORWARDING_EN
            .fwd_lat_i (fwd_clamp),
`endif
            .busy_o    (busy_mask[r]),
            .chk_o     (chk[r])
        );
    end

    assign stall_d = (hazard && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed checks of hazard_scoreboard against a per-register timer model.
module tb_hazard_scoreboard;

    localparam int AW = 4;
    localparam int NS = 3;
    localparam int ML = 3;
    localparam int CW = 2;
    localparam int SW = 16;
    localparam int NR = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*AW-1:0]  src_addr;
    logic [NS-1:0]     src_valid;
    logic              issue_valid;
    logic              issue_wb_en;
    logic [AW-1:0]     issue_dest;
    logic [CW-1:0]     issue_lat;
    logic [CW-1:0]     issue_fwd_lat;
    logic              flush;
    logic              hazard;
    logic [NR-1:0]     busy_mask;
    logic [SW-1:0]     stall_count;

    hazard_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .src_addr      (src_addr),
        .src_valid     (src_valid),
        .issue_valid   (issue_valid),
        .issue_wb_en   (issue_wb_en),
        .issue_dest    (issue_dest),
        .issue_lat     (issue_lat),
        .issue_fwd_lat (issue_fwd_lat),
        .flush         (flush),
        .hazard        (hazard),
        .busy_mask     (busy_mask),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_cnt [NR];
    int m_fcnt [NR];
    int m_stall;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_cnt[r]  = 0;
            m_fcnt[r] = 0;
        end
        m_stall = 0;
    endtask

    // A read is blocked while its register's result is not yet available to it.
    function automatic bit model_hazard();
        bit any;
        any = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int a;
            a = int'(src_addr[i*AW +: AW]);
`ifdef HAZARD_FORWARDING_EN
            if (src_valid[i] && m_fcnt[a] > 0) any = 1'b1;
`else
            if (src_valid[i] && m_cnt[a] > 0) any = 1'b1;
`endif
        end
        return issue_valid && !flush && any;
    endfunction

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] m;
        for (int r = 0; r < NR; r++) m[r] = (m_cnt[r] > 0);
        return m;
    endfunction

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        bit hz;
        bit acc;
        int lat;
        int flat;
        @(negedge clk);
        hz = model_hazard();
        check_eq("hazard", {63'd0, hazard}, {63'd0, hz});
        check_eq("busy_mask", 64'(busy_mask), 64'(model_busy()));
        check_eq("stall_count", 64'(stall_count), 64'(m_stall));
        acc  = issue_valid && !flush && !hz && issue_wb_en && issue_lat != 0;
        lat  = imin(int'(issue_lat), ML);
        flat = imin(int'(issue_fwd_lat), lat);
        for (int r = 0; r < NR; r++) begin
            int d;
            int fd;
            d  = imax(m_cnt[r] - 1, 0);
            fd = imax(m_fcnt[r] - 1, 0);
            if (acc && r == int'(issue_dest)) begin
                d  = imax(lat, d);
                fd = imax(flat, fd);
            end
            m_cnt[r]  = d;
            m_fcnt[r] = fd;
        end
        if (hz && m_stall != 65535) m_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        issue_valid   = 1'b0;
        issue_wb_en   = 1'b0;
        issue_dest    = '0;
        issue_lat     = '0;
        issue_fwd_lat = '0;
        src_addr      = '0;
        src_valid     = '0;
        flush         = 1'b0;
    endtask

    task automatic set_issue(input int dest, input int lat, input int flat);
        set_idle();
        issue_valid   = 1'b1;
        issue_wb_en   = 1'b1;
        issue_dest    = AW'(dest);
        issue_lat     = CW'(lat);
        issue_fwd_lat = CW'(flat);
    endtask

    task automatic set_read(input int slot, input int addr);
        set_idle();
        issue_valid = 1'b1;
        src_addr[slot*AW +: AW] = AW'(addr);
        src_valid[slot] = 1'b1;
    endtask

    task automatic drain();
        set_idle();
        for (int k = 0; k < ML + 1; k++) cycle();
    endtask

    logic [SW-1:0] sc0;
    int exp_load_stalls;
    int exp_alu_stalls;

    initial begin
        set_idle();
        model_reset();
        rst = 1'b1;
        #1;
        check_eq("reset_busy", 64'(busy_mask), 64'd0);
        check_eq("reset_stall", 64'(stall_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            issue_valid   = ($urandom_range(3, 0) != 0);
            issue_wb_en   = $urandom_range(1, 0) == 1;
            issue_dest    = AW'($urandom_range(NR - 1, 0));
            issue_lat     = CW'($urandom_range(3, 0));
            issue_fwd_lat = CW'($urandom_range(3, 0));
            src_addr      = (NS*AW)'($urandom);
            src_valid     = NS'($urandom);
            flush         = ($urandom_range(9, 0) == 0);
            cycle();
        end
        drain();

        // RAW stall on src0
        set_issue(5, 2, 2);
        cycle();
        set_read(0, 5);
        sc0 = stall_count;
        cycle();
        cycle();
        check_eq("raw_released", {63'd0, hazard}, 64'd0);
        cycle();
        check_eq("raw_stalls", 64'(stall_count - sc0), 64'd2);
        drain();

        // Operand qualification: src1 names a busy reg but is not read
        set_issue(7, 3, 3);
        cycle();
        set_idle();
        issue_valid = 1'b1;
        src_addr    = {AW'(0), AW'(7), AW'(0)};
        src_valid   = 3'b001;
        #1;
        check_eq("qualify", {63'd0, hazard}, 64'd0);
        cycle();
        drain();

        // WAW never shortens the entry
        set_issue(2, 3, 3);
        cycle();
        set_issue(2, 1, 1);
        cycle();
        set_idle();
        check_eq("waw_busy0", 64'(busy_mask[2]), 64'd1);
        cycle();
        check_eq("waw_busy1", 64'(busy_mask[2]), 64'd1);
        cycle();
        check_eq("waw_clear", 64'(busy_mask[2]), 64'd0);
        drain();

        // Flush squashes the ID instruction but older entries keep retiring
        set_issue(4, 3, 3);
        cycle();
        set_issue(9, 3, 3);
        src_addr[AW-1:0] = AW'(4);
        src_valid        = 3'b001;
        flush            = 1'b1;
        #1;
        check_eq("flush_hazard", {63'd0, hazard}, 64'd0);
        cycle();
        check_eq("flush_noload", 64'(busy_mask[9]), 64'd0);
        set_idle();
        cycle();
        cycle();
        check_eq("flush_decay", 64'(busy_mask[4]), 64'd0);
        drain();

`ifdef HAZARD_FORWARDING_EN
        exp_load_stalls = 1;
        exp_alu_stalls  = 0;
`else
        exp_load_stalls = 2;
        exp_alu_stalls  = 2;
`endif
        // Load-use and ALU-use
        set_issue(1, 2, 1);
        cycle();
        set_read(0, 1);
        sc0 = stall_count;
        for (int k = 0; k < 3; k++) cycle();
        check_eq("load_use_stalls", 64'(stall_count - sc0), 64'(exp_load_stalls));
        drain();
        set_issue(1, 2, 0);
        cycle();
        set_read(0, 1);
        sc0 = stall_count;
        for (int k = 0; k < 3; k++) cycle();
        check_eq("alu_use_stalls", 64'(stall_count - sc0), 64'(exp_alu_stalls));
        drain();

        // Asynchronous reset in the middle of a count
        set_read(0, 0);
        set_issue(3, 3, 3);
        cycle();
        check_eq("pre_reset_busy", 64'(busy_mask[3]), 64'd1);
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_busy", 64'(busy_mask), 64'd0);
        check_eq("async_rst_stall", 64'(stall_count), 64'd0);
        model_reset();
        #1;
        rst = 1'b0;
        set_read(0, 3);
        cycle();
        check_eq("post_reset_read", {63'd0, hazard}, 64'd0);
        set_idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
